// File: rtl/risc8_uart_rx.sv
// risc8_uart_rx: oversampling 8N1 UART receiver for the risc8 IO bus.
// Bytes land in a small circular FIFO. Baud divisor, status and data are exposed as IO registers.
module risc8_uart_rx #(
   parameter logic [6:0] BASE       = 7'h30,
   parameter int         DEPTH_LOG2 = 2
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       ren,
   input  logic       wen,
   input  logic [6:0] addr,
   input  logic [7:0] wdata,
   output logic [7:0] rdata,
   output logic       valid,
   input  logic       rx_in,
   output logic       rx_avail
);
   localparam int DEPTH = 1 << DEPTH_LOG2;
   localparam int PW    = DEPTH_LOG2;
   localparam int CW    = DEPTH_LOG2 + 1;
   localparam logic [6:0] A_BAUD = BASE;
   localparam logic [6:0] A_STAT = BASE + 7'd1;
   localparam logic [6:0] A_DATA = BASE + 7'd2;

   typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

   state_t          state_q, state_d;
   logic            sync_q, rxs_q;
   logic [7:0]      cnt_q, cnt_d;
   logic [2:0]      idx_q, idx_d;
   logic [7:0]      shreg_q, shreg_d;
   logic            cnt_zero, push, frame_bad;

   logic [7:0]      baud_q, baud_d;
   logic            ovr_q, ovr_d, ferr_q, ferr_d, avail_q;
   logic [7:0]      mem_q [DEPTH];
   logic [PW-1:0]   wptr_q, wptr_d, rptr_q, rptr_d;
   logic [CW-1:0]   count_q, count_d;
   logic [7:0]      rdata_q, rdata_d;
   logic            valid_q, valid_d;
   logic            sel_baud, sel_stat, sel_data, empty, full, pop, push_ok, ovr_set;

   always_ff @(posedge clk) begin
      if (reset) begin
         sync_q <= 1'b1;
         rxs_q  <= 1'b1;
      end else begin
         sync_q <= rx_in;
         rxs_q  <= sync_q;
      end
   end

   assign cnt_zero = (cnt_q == 8'd0);

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         cnt_q   <= 8'd0;
         idx_q   <= 3'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
      end
   end

   always_ff @(posedge clk) begin
      shreg_q <= shreg_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (!rxs_q) state_d = S_START;
         S_START: if (cnt_zero) state_d = rxs_q ? S_IDLE : S_DATA;
         S_DATA:  if (cnt_zero && idx_q == 3'd7) state_d = S_STOP;
         S_STOP:  if (cnt_zero) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Reloads read baud_q directly, so a divisor write lands at the next bit boundary.
   always_comb begin
      cnt_d     = cnt_q;
      idx_d     = idx_q;
      shreg_d   = shreg_q;
      push      = 1'b0;
      frame_bad = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (!rxs_q) cnt_d = {1'b0, baud_q[7:1]};
         end
         S_START: begin
            if (cnt_zero) begin
               cnt_d = baud_q;
               idx_d = 3'd0;
            end else begin
               cnt_d = cnt_q - 8'd1;
            end
         end
         S_DATA: begin
            if (cnt_zero) begin
               shreg_d[idx_q] = rxs_q;
               cnt_d          = baud_q;
               idx_d          = idx_q + 3'd1;
            end else begin
               cnt_d = cnt_q - 8'd1;
            end
         end
         S_STOP: begin
            if (cnt_zero) begin
               push      = rxs_q;
               frame_bad = !rxs_q;
            end else begin
               cnt_d = cnt_q - 8'd1;
            end
         end
         default: ;
      endcase
   end

   // A pop frees the slot in the same cycle, so a push to a full FIFO only fails without one.
   always_comb begin
      sel_baud = (addr == A_BAUD);
      sel_stat = (addr == A_STAT);
      sel_data = (addr == A_DATA);
      empty    = (count_q == '0);
      full     = (count_q == CW'(DEPTH));
      pop      = ren && sel_data && !empty;
      push_ok  = push && (!full || pop);
      ovr_set  = push && full && !pop;

      wptr_d  = push_ok ? wptr_q + PW'(1) : wptr_q;
      rptr_d  = pop ? rptr_q + PW'(1) : rptr_q;
      count_d = count_q;
      if (push_ok && !pop)      count_d = count_q + CW'(1);
      else if (pop && !push_ok) count_d = count_q - CW'(1);

      rdata_d = rdata_q;
      valid_d = 1'b0;
      if (ren && (sel_baud || sel_stat || sel_data)) begin
         valid_d = 1'b1;
         if (sel_baud)      rdata_d = baud_q;
         else if (sel_stat) rdata_d = {5'b0, ferr_q, ovr_q, avail_q};
         else               rdata_d = empty ? 8'h00 : mem_q[rptr_q];
      end

      baud_d = (wen && sel_baud) ? wdata : baud_q;
      ovr_d  = ovr_set   || (ovr_q  && !(wen && sel_stat && wdata[1]));
      ferr_d = frame_bad || (ferr_q && !(wen && sel_stat && wdata[2]));
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         baud_q  <= 8'h05;
         ovr_q   <= 1'b0;
         ferr_q  <= 1'b0;
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
         avail_q <= 1'b0;
         rdata_q <= 8'h00;
         valid_q <= 1'b0;
      end else begin
         baud_q  <= baud_d;
         ovr_q   <= ovr_d;
         ferr_q  <= ferr_d;
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         count_q <= count_d;
         avail_q <= (count_d != '0);
         rdata_q <= rdata_d;
         valid_q <= valid_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push_ok) mem_q[wptr_q] <= shreg_q;
   end

   assign rdata    = rdata_q;
   assign valid    = valid_q;
   assign rx_avail = avail_q;

endmodule

// File: tb/tb_risc8_uart_rx.sv
// Bench for risc8_uart_rx: directed scenarios plus random frames and bus traffic,
// checked against a queue-based model of the receiver's visible behaviour.
module tb_risc8_uart_rx;
   localparam logic [6:0] BASE = 7'h30;

   logic       clk = 1'b0;
   logic       reset, ren, wen, rx_in, valid, rx_avail;
   logic [6:0] addr;
   logic [7:0] wdata, rdata;

   int checks = 0;
   int errors = 0;

   logic [7:0] q[$];
   bit         m_ovr, m_ferr;
   int         baud_m;
   logic [7:0] m_rdata;

   risc8_uart_rx #(.BASE(BASE), .DEPTH_LOG2(2)) dut (
      .clk(clk), .reset(reset), .ren(ren), .wen(wen), .addr(addr), .wdata(wdata),
      .rdata(rdata), .valid(valid), .rx_in(rx_in), .rx_avail(rx_avail)
   );

   always #5 clk = ~clk;

   initial begin
      #3000000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1);
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic model_reset();
      q.delete();
      m_ovr   = 1'b0;
      m_ferr  = 1'b0;
      baud_m  = 5;
      m_rdata = 8'h00;
   endtask

   task automatic io_read(input logic [6:0] a, output logic [7:0] d, output logic v);
      addr = a;
      ren  = 1'b1;
      tick();
      ren = 1'b0;
      d   = rdata;
      v   = valid;
   endtask

   task automatic io_write(input logic [6:0] a, input logic [7:0] d);
      addr  = a;
      wdata = d;
      wen   = 1'b1;
      tick();
      wen = 1'b0;
   endtask

   task automatic rd_data();
      logic [7:0] d, e;
      logic       v;
      io_read(BASE + 7'd2, d, v);
      e = (q.size() != 0) ? q.pop_front() : 8'h00;
      chk("data", d, e);
      chk("data_valid", v, 1);
      m_rdata = e;
      tick();
      chk("valid_pulse", valid, 0);
   endtask

   task automatic rd_status();
      logic [7:0] d, e;
      logic       v;
      io_read(BASE + 7'd1, d, v);
      e = {5'b0, m_ferr, m_ovr, (q.size() != 0)};
      chk("status", d, e);
      chk("status_valid", v, 1);
      m_rdata = e;
   endtask

   task automatic rd_baud();
      logic [7:0] d, e;
      logic       v;
      io_read(BASE, d, v);
      e = 8'(baud_m);
      chk("baud", d, e);
      chk("baud_valid", v, 1);
      m_rdata = e;
   endtask

   task automatic wr_baud(input logic [7:0] v);
      io_write(BASE, v);
      baud_m = int'(v);
   endtask

   task automatic wr_status(input logic [7:0] v);
      io_write(BASE + 7'd1, v);
      if (v[1]) m_ovr = 1'b0;
      if (v[2]) m_ferr = 1'b0;
   endtask

   // Drives one 8N1 frame at the model's bit period. rd_at issues a data read in that
   // loop iteration; rst_at pulses reset there and abandons the frame.
   task automatic send_frame(input logic [7:0] b, input bit stop_ok, input int rd_at, input int rst_at);
      int         bt = baud_m + 1;
      int         len = 10 * bt;
      logic [9:0] bits;
      bit         popped = 1'b0;
      logic [7:0] e;
      bits = {stop_ok, b, 1'b0};
      if (rd_at >= len) len = rd_at + 1;
      for (int i = 0; i < len; i++) begin
         rx_in = (i / bt < 10) ? bits[i / bt] : 1'b1;
         if (i == rst_at) begin
            reset = 1'b1;
            tick();
            reset = 1'b0;
            rx_in = 1'b1;
            model_reset();
            chk("rst_rdata", rdata, 0);
            chk("rst_valid", valid, 0);
            chk("rst_avail", rx_avail, 0);
            repeat (2 * bt + 8) tick();
            return;
         end
         if (i == rd_at) begin
            addr = BASE + 7'd2;
            ren  = 1'b1;
         end
         tick();
         if (i == rd_at) begin
            ren    = 1'b0;
            popped = (q.size() != 0);
            e      = popped ? q[0] : 8'h00;
            chk("frame_rd", rdata, e);
            chk("frame_rd_valid", valid, 1);
            m_rdata = e;
         end
      end
      rx_in = 1'b1;
      repeat (2 * bt + 8) tick();
      if (popped) void'(q.pop_front());
      if (stop_ok) begin
         if (q.size() < 4) q.push_back(b);
         else m_ovr = 1'b1;
      end else begin
         m_ferr = 1'b1;
      end
      chk("rx_avail", rx_avail, (q.size() != 0));
   endtask

   initial begin
      logic [7:0] d;
      logic       v;
      logic [6:0] bad_addr [2];
      reset = 1'b1; ren = 1'b0; wen = 1'b0; addr = '0; wdata = '0; rx_in = 1'b1;
      tick();
      tick();
      chk("reset_rdata", rdata, 0);
      chk("reset_valid", valid, 0);
      chk("reset_avail", rx_avail, 0);
      reset = 1'b0;
      model_reset();
      rd_status();
      rd_baud();

      // single frame at default divisor
      send_frame(8'hA5, 1'b1, -1, -1);
      rd_status();
      rd_data();
      rd_status();

      // short low glitch is rejected as a false start
      rx_in = 1'b0;
      tick();
      tick();
      rx_in = 1'b1;
      repeat (20) tick();
      chk("glitch_avail", rx_avail, 0);
      rd_status();

      // framing error, then off-window accesses must not disturb anything
      send_frame(8'h3C, 1'b0, -1, -1);
      rd_status();
      bad_addr[0] = BASE - 7'd1;
      bad_addr[1] = BASE + 7'd3;
      for (int k = 0; k < 2; k++) begin
         io_write(bad_addr[k], 8'hFF);
         io_read(bad_addr[k], d, v);
         chk("decode_valid", v, 0);
         chk("decode_rdata", d, m_rdata);
      end
      rd_status();
      rd_baud();
      wr_status(8'h04);
      rd_status();

      // overrun after five unread frames
      for (int k = 1; k <= 5; k++) send_frame(8'(k), 1'b1, -1, -1);
      rd_status();
      for (int k = 0; k < 5; k++) rd_data();
      rd_status();
      wr_status(8'h02);
      rd_status();

      // pointer wrap and a data read on the same edge as a push into a full FIFO
      send_frame(8'h11, 1'b1, -1, -1);
      send_frame(8'h22, 1'b1, -1, -1);
      rd_data();
      rd_data();
      for (int k = 0; k < 4; k++) send_frame(8'h40 + 8'(k), 1'b1, -1, -1);
      send_frame(8'h77, 1'b1, 3 + (baud_m >> 1) + 9 * (baud_m + 1), -1);
      rd_status();
      for (int k = 0; k < 4; k++) rd_data();
      rd_status();

      // slower divisor
      wr_baud(8'h0F);
      rd_baud();
      send_frame(8'h5A, 1'b1, -1, -1);
      rd_data();
      wr_baud(8'h05);

      // reset during data bit 4 with bytes queued
      send_frame(8'hC3, 1'b1, -1, -1);
      send_frame(8'h96, 1'b1, -1, -1);
      send_frame(8'hE7, 1'b1, -1, 5 * (baud_m + 1) + (baud_m + 1) / 2);
      rd_status();
      rd_baud();
      send_frame(8'h69, 1'b1, -1, -1);
      rd_data();

      // random mix of frames and bus traffic
      for (int n = 0; n < 40; n++) begin
         int act;
         act = int'($urandom_range(0, 9));
         if (act < 5) send_frame(8'($urandom), ($urandom_range(0, 7) != 0), -1, -1);
         else if (act < 7) rd_data();
         else if (act == 7) rd_status();
         else if (act == 8) wr_status(8'($urandom));
         else begin
            wr_baud(8'($urandom_range(2, 9)));
            rd_baud();
         end
      end
      while (q.size() != 0) rd_data();
      rd_status();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
